// File: rtl/uart_line_rx_pkg.sv
// Shared types and constants for the UART line handler: FSM states, control bytes,
// the expected greeting and the two fixed reply strings.
package uart_line_pkg;

    typedef enum logic [1:0] {
        RECV  = 2'd0,
        CHECK = 2'd1,
        REPLY = 2'd2
    } state_e;

    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

    localparam int GREETING_LEN = 11;
    localparam logic [8*GREETING_LEN-1:0] GREETING = "HELLO ALINX";

    localparam int REPLY_LEN = 5;
    localparam logic [8*REPLY_LEN-1:0] ACK_ROM = {8'h41, 8'h43, 8'h4B, CR, LF};
    localparam logic [8*REPLY_LEN-1:0] NAK_ROM = {8'h4E, 8'h41, 8'h4B, CR, LF};

    // Byte 0 is the leftmost character of the packed string.
    function automatic logic [7:0] greeting_byte(input int idx);
        return GREETING[8*(GREETING_LEN-1-idx) +: 8];
    endfunction

    function automatic logic [7:0] reply_byte(input logic is_ack, input int idx);
        logic [8*REPLY_LEN-1:0] rom;
        rom = is_ack ? ACK_ROM : NAK_ROM;
        return rom[8*(REPLY_LEN-1-idx) +: 8];
    endfunction

endpackage

// File: rtl/uart_line_rx_if.sv
// Byte streams between the line handler and the UART rx/tx instances.
// slave is the line handler's view; master is the peer side (receiver + transmitter).
interface uart_line_rx_if;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       rx_data_ready;
    logic [7:0] tx_data;
    logic       tx_data_valid;
    logic       tx_data_ready;

    modport slave (
        input  rx_data, rx_data_valid,
        output rx_data_ready,
        output tx_data, tx_data_valid,
        input  tx_data_ready
    );

    modport master (
        output rx_data, rx_data_valid,
        input  rx_data_ready,
        input  tx_data, tx_data_valid,
        output tx_data_ready
    );
endinterface

// File: rtl/uart_line_rx_reply_tx.sv
// Streams a 5-byte ACK/NAK reply; first byte valid the cycle after start_i.
// Holds tx_data/tx_data_valid while tx_data_ready is low; done_o marks the last transfer.
module uart_reply_tx
    import uart_line_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic       ack_i,
    output logic [7:0] tx_data_o,
    output logic       tx_data_valid_o,
    input  logic       tx_data_ready_i,
    output logic       done_o
);

    logic [2:0] idx_q, idx_d;
    logic       ack_q, ack_d;
    logic       vld_q, vld_d;
    logic [7:0] dat_q, dat_d;
    logic       xfer;
    logic       last;

    assign xfer = vld_q && tx_data_ready_i;
    assign last = (idx_q == 3'(REPLY_LEN - 1));

    always_comb begin
        idx_d  = idx_q;
        ack_d  = ack_q;
        vld_d  = vld_q;
        dat_d  = dat_q;
        done_o = 1'b0;
        if (start_i) begin
            idx_d = '0;
            ack_d = ack_i;
            vld_d = 1'b1;
            dat_d = reply_byte(ack_i, 0);
        end else if (xfer) begin
            if (last) begin
                vld_d  = 1'b0;
                done_o = 1'b1;
            end else begin
                idx_d = idx_q + 3'd1;
                dat_d = reply_byte(ack_q, int'(idx_q) + 1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
            ack_q <= 1'b0;
            vld_q <= 1'b0;
            dat_q <= '0;
        end else begin
            idx_q <= idx_d;
            ack_q <= ack_d;
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign tx_data_o       = dat_q;
    assign tx_data_valid_o = vld_q;

endmodule

// File: rtl/uart_line_rx.sv
// Assembles LF-terminated lines, compares them to the greeting and answers ACK/NAK.
// First reply byte valid 2 cycles after the LF; rx is stalled (ready low) until the reply completes.
module uart_line_rx
    import uart_line_pkg::*;
#(
    parameter int CLK_FRE    = 50,
    parameter int MAX_LEN    = 16,
    parameter int TIMEOUT_MS = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_line_rx_if.slave lnk,
    output logic          line_match,
    output logic          line_overflow,
    output logic [7:0]    line_len,
    output logic [15:0]   match_cnt
);

    localparam int unsigned TO_LIMIT = CLK_FRE * 1000 * TIMEOUT_MS;
    localparam int          TO_W     = $clog2(TO_LIMIT + 1);
    localparam int          CNT_W    = $clog2(MAX_LEN + 1);
    localparam int          IDX_W    = $clog2(MAX_LEN);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    logic [TO_W-1:0]    to_q, to_d;
    logic [7:0]         line_len_q, line_len_d;
    logic               match_q, match_d;
    logic               ovf_pls_q, ovf_pls_d;
    logic [15:0]        match_cnt_q, match_cnt_d;

    logic [7:0]         line_buf_q [MAX_LEN];
    logic               wr_en;
    logic               rx_acc;
    logic               line_eq;
    logic               reply_start;
    logic               reply_done;

    assign lnk.rx_data_ready = (state_q == RECV);
    assign rx_acc            = lnk.rx_data_valid && (state_q == RECV);

    always_comb begin
        line_eq = (count_q == CNT_W'(GREETING_LEN)) && !ovf_q;
        for (int i = 0; i < GREETING_LEN; i++) begin
            if (line_buf_q[i] != greeting_byte(i)) begin
                line_eq = 1'b0;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        to_d        = to_q;
        line_len_d  = line_len_q;
        match_d     = 1'b0;
        ovf_pls_d   = 1'b0;
        match_cnt_d = match_cnt_q;
        wr_en       = 1'b0;
        reply_start = 1'b0;
        case (state_q)
            RECV: begin
                if (rx_acc) begin
                    to_d = '0;
                    if (lnk.rx_data == CR) begin
                        count_d = count_q;
                    end else if (lnk.rx_data == LF) begin
                        if (count_q != '0) begin
                            line_len_d = 8'(count_q);
                            state_d    = CHECK;
                        end
                    end else if (count_q < CNT_W'(MAX_LEN)) begin
                        wr_en   = 1'b1;
                        count_d = count_q + 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else if (count_q != '0) begin
                    // A stalled partial line is dropped without reply or pulses.
                    if (to_q == TO_W'(TO_LIMIT - 1)) begin
                        count_d = '0;
                        ovf_d   = 1'b0;
                        to_d    = '0;
                    end else begin
                        to_d = to_q + 1'b1;
                    end
                end
            end
            CHECK: begin
                match_d     = line_eq;
                ovf_pls_d   = ovf_q;
                reply_start = 1'b1;
                if (line_eq) begin
                    match_cnt_d = match_cnt_q + 16'd1;
                end
                state_d = REPLY;
            end
            REPLY: begin
                if (reply_done) begin
                    count_d = '0;
                    ovf_d   = 1'b0;
                    state_d = RECV;
                end
            end
            default: state_d = RECV;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RECV;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            to_q        <= '0;
            line_len_q  <= '0;
            match_q     <= 1'b0;
            ovf_pls_q   <= 1'b0;
            match_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            to_q        <= to_d;
            line_len_q  <= line_len_d;
            match_q     <= match_d;
            ovf_pls_q   <= ovf_pls_d;
            match_cnt_q <= match_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                line_buf_q[i] <= '0;
            end
        end else if (wr_en) begin
            line_buf_q[count_q[IDX_W-1:0]] <= lnk.rx_data;
        end
    end

    uart_reply_tx u_reply (
        .clk             (clk),
        .rst_n           (rst_n),
        .start_i         (reply_start),
        .ack_i           (line_eq),
        .tx_data_o       (lnk.tx_data),
        .tx_data_valid_o (lnk.tx_data_valid),
        .tx_data_ready_i (lnk.tx_data_ready),
        .done_o          (reply_done)
    );

    assign line_match    = match_q;
    assign line_overflow = ovf_pls_q;
    assign line_len      = line_len_q;
    assign match_cnt     = match_cnt_q;

endmodule

// File: tb/tb_uart_line_rx.sv
// Directed bench for uart_line_rx with a 1000-cycle timeout (CLK_FRE=1, TIMEOUT_MS=1).
module tb_uart_line_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        line_match;
    logic        line_overflow;
    logic [7:0]  line_len;
    logic [15:0] match_cnt;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] txq [$];
    int vld_cyc   = 0;
    int match_cyc = 0;
    int ovf_cyc   = 0;

    always #5 clk = ~clk;

    uart_line_rx_if lnk ();

    uart_line_rx #(
        .CLK_FRE    (1),
        .MAX_LEN    (16),
        .TIMEOUT_MS (1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .lnk           (lnk),
        .line_match    (line_match),
        .line_overflow (line_overflow),
        .line_len      (line_len),
        .match_cnt     (match_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    // Sample just before each rising edge: counts tx-valid cycles, pulse cycles, and transfers.
    always begin
        @(negedge clk);
        #3;
        if (rst_n) begin
            if (lnk.tx_data_valid) begin
                vld_cyc++;
                if (lnk.tx_data_ready) txq.push_back(lnk.tx_data);
            end
            if (line_match)    match_cyc++;
            if (line_overflow) ovf_cyc++;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        @(negedge clk);
        while (!lnk.rx_data_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!lnk.rx_data_ready) check("rx_rdy_wait", 32'(lnk.rx_data_ready), 1);
        lnk.rx_data       = b;
        lnk.rx_data_valid = 1'b1;
        @(negedge clk);
        lnk.rx_data_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic wait_reply();
        int g = 0;
        while ((txq.size() < 5 || lnk.tx_data_valid) && g < 200) begin
            @(negedge clk);
            g++;
        end
        check("reply_cnt", 32'(txq.size()), 5);
        check("reply_end_vld", 32'(lnk.tx_data_valid), 0);
    endtask

    task automatic check_reply(input bit ack);
        logic [7:0] exp_r [5];
        if (ack) exp_r = '{8'h41, 8'h43, 8'h4B, 8'h0D, 8'h0A};
        else     exp_r = '{8'h4E, 8'h41, 8'h4B, 8'h0D, 8'h0A};
        for (int i = 0; i < 5; i++) begin
            if (i < txq.size()) check("reply_byte", 32'(txq[i]), 32'(exp_r[i]));
        end
    endtask

    // Sends body + LF with tx_data_ready high and checks timing, pulses and reply.
    task automatic run_line(input string body, input bit ack, input bit ovf,
                            input logic [7:0] exp_len, input logic [15:0] exp_cnt);
        int m0 = match_cyc;
        int o0 = ovf_cyc;
        txq.delete();
        send_str(body);
        send_byte(8'h0A);
        check("check_vld", 32'(lnk.tx_data_valid), 0);
        check("check_rdy", 32'(lnk.rx_data_ready), 0);
        @(negedge clk);
        check("first_vld", 32'(lnk.tx_data_valid), 1);
        check("first_dat", 32'(lnk.tx_data), ack ? 32'h41 : 32'h4E);
        check("match_pls", 32'(line_match), 32'(ack));
        check("ovf_pls", 32'(line_overflow), 32'(ovf));
        wait_reply();
        check_reply(ack);
        check("match_width", 32'(match_cyc - m0), 32'(ack));
        check("ovf_width", 32'(ovf_cyc - o0), 32'(ovf));
        check("line_len", 32'(line_len), 32'(exp_len));
        check("match_cnt", 32'(match_cnt), 32'(exp_cnt));
        check("rdy_back", 32'(lnk.rx_data_ready), 1);
    endtask

    task automatic wait_tx_valid();
        int g = 0;
        while (!lnk.tx_data_valid && g < 50) begin
            @(negedge clk);
            g++;
        end
        check("wait_vld", 32'(lnk.tx_data_valid), 1);
    endtask

    initial begin
        int v0;
        int m0;
        lnk.rx_data       = 8'h00;
        lnk.rx_data_valid = 1'b0;
        lnk.tx_data_ready = 1'b1;
        #22;
        check("rst_rdy", 32'(lnk.rx_data_ready), 1);
        check("rst_vld", 32'(lnk.tx_data_valid), 0);
        check("rst_dat", 32'(lnk.tx_data), 0);
        check("rst_match", 32'(line_match), 0);
        check("rst_ovf", 32'(line_overflow), 0);
        check("rst_len", 32'(line_len), 0);
        check("rst_cnt", 32'(match_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_line("HELLO ALINX\r", 1'b1, 1'b0, 8'd11, 16'd1);
        run_line("HELLO ALINY", 1'b0, 1'b0, 8'd11, 16'd1);
        run_line("AAAAAAAAAAAAAAAAAAAA", 1'b0, 1'b1, 8'd16, 16'd1);
        run_line("hello alinx", 1'b0, 1'b0, 8'd11, 16'd1);

        // Empty line: CR and a bare LF must produce nothing.
        v0 = vld_cyc;
        m0 = match_cyc + ovf_cyc;
        send_str("\r\n");
        repeat (10) @(negedge clk);
        check("empty_novld", 32'(vld_cyc - v0), 0);
        check("empty_nopls", 32'(match_cyc + ovf_cyc - m0), 0);
        check("empty_len", 32'(line_len), 11);
        run_line("HELLO ALINX", 1'b1, 1'b0, 8'd11, 16'd2);

        // Partial line expires; the following greeting stands alone.
        v0 = vld_cyc;
        send_str("HEL");
        repeat (1100) @(negedge clk);
        check("to_novld", 32'(vld_cyc - v0), 0);
        run_line("HELLO ALINX", 1'b1, 1'b0, 8'd11, 16'd3);

        // Gap just under the limit keeps the partial line alive.
        send_str("HEL");
        repeat (900) @(negedge clk);
        run_line("LO ALINX", 1'b1, 1'b0, 8'd11, 16'd4);

        // Stall on reply byte 2 for 7 cycles.
        lnk.tx_data_ready = 1'b0;
        txq.delete();
        send_str("HELLO ALINX\n");
        wait_tx_valid();
        check("stall_first", 32'(lnk.tx_data), 32'h41);
        lnk.tx_data_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        lnk.tx_data_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check("stall_vld", 32'(lnk.tx_data_valid), 1);
            check("stall_dat", 32'(lnk.tx_data), 32'h4B);
        end
        lnk.tx_data_ready = 1'b1;
        wait_reply();
        check_reply(1'b1);
        check("stall_cnt", 32'(match_cnt), 5);

        // Reset in the middle of a stalled reply.
        lnk.tx_data_ready = 1'b0;
        send_str("HELLO ALINX\n");
        wait_tx_valid();
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_rdy", 32'(lnk.rx_data_ready), 1);
        check("mid_rst_vld", 32'(lnk.tx_data_valid), 0);
        check("mid_rst_dat", 32'(lnk.tx_data), 0);
        check("mid_rst_match", 32'(line_match), 0);
        check("mid_rst_ovf", 32'(line_overflow), 0);
        check("mid_rst_len", 32'(line_len), 0);
        check("mid_rst_cnt", 32'(match_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        lnk.tx_data_ready = 1'b1;
        run_line("HELLO ALINX", 1'b1, 1'b0, 8'd11, 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
